// File: rtl/bus_fetch_ctrl_if.sv
// Signal bundle between the fetch controller and the PC/AR/IR/memory datapath.
// The slave modport is the controller's view; the master modport is the datapath/driver view.
interface bus_fetch_ctrl_if;
    logic        start;
    logic        halt;
    logic        mem_ready;
    logic [15:0] ir_in;
    logic        pc_read;
    logic        pc_inc;
    logic        ar_load;
    logic        ar_read;
    logic        ir_read;
    logic        ir_load;
    logic        mem_read;
    logic [2:0]  t_state;
    logic        busy;
    logic        fetch_done;
    logic [2:0]  opcode;
    logic        indirect;
    logic        bus_err;
    logic [15:0] fetch_cnt;

    modport slave (
        input  start, halt, mem_ready, ir_in,
        output pc_read, pc_inc, ar_load, ar_read, ir_read, ir_load, mem_read,
               t_state, busy, fetch_done, opcode, indirect, bus_err, fetch_cnt
    );

    modport master (
        output start, halt, mem_ready, ir_in,
        input  pc_read, pc_inc, ar_load, ar_read, ir_read, ir_load, mem_read,
               t_state, busy, fetch_done, opcode, indirect, bus_err, fetch_cnt
    );
endinterface

// File: rtl/bus_fetch_ctrl.sv
// Instruction-fetch sequencer: T0 (PC->AR), T1 (M[AR]->IR, PC++), T2 (IR->AR, decode),
// optional T3 indirect (M[AR]->AR), with memory-wait timeout into a sticky error state.
module bus_fetch_ctrl #(
    parameter int unsigned TIMEOUT = 15   // legal range 1..255
) (
    input  logic           clk,
    input  logic           reset,
    bus_fetch_ctrl_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_T0   = 3'd1,
        S_T1   = 3'd2,
        S_T2   = 3'd3,
        S_T3   = 3'd4,
        S_ERR  = 3'd7
    } state_t;

    localparam logic [7:0] WAIT_LIMIT = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_next;
    logic [7:0]  r_wait;
    logic [15:0] r_fetch_cnt;
    logic [2:0]  r_opcode;
    logic        r_indirect;
    logic        r_fetch_done;
    logic        w_complete;
    logic        w_mem_phase;
    logic        w_timeout;
    logic        w_pc_read, w_pc_inc, w_ar_load, w_ar_read;
    logic        w_ir_read, w_ir_load, w_mem_read;
    logic        w_unused_ir;

    assign w_unused_ir = ^bus.ir_in[11:0];
    assign w_mem_phase = (r_state == S_T1) || (r_state == S_T3);
    assign w_timeout   = w_mem_phase && !bus.mem_ready && (r_wait == WAIT_LIMIT);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state decode; completion picks IDLE or a back-to-back T0 from halt
    always_comb begin
        w_next     = r_state;
        w_complete = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) w_next = S_T0;
                else           w_next = S_IDLE;
            end
            S_T0: w_next = S_T1;
            S_T1: begin
                if (bus.mem_ready) w_next = S_T2;
                else if (w_timeout) w_next = S_ERR;
                else                w_next = S_T1;
            end
            S_T2: begin
                if (bus.ir_in[15]) w_next = S_T3;
                else               w_complete = 1'b1;
            end
            S_T3: begin
                if (bus.mem_ready) w_complete = 1'b1;
                else if (w_timeout) w_next = S_ERR;
                else                w_next = S_T3;
            end
            S_ERR: begin
                if (bus.start) w_next = S_T0;
                else           w_next = S_ERR;
            end
            default: w_next = S_IDLE;
        endcase
        if (w_complete) begin
            w_next = bus.halt ? S_IDLE : S_T0;
        end else begin
            w_next = w_next;
        end
    end

    // Moore strobe decode; only ir_load, pc_inc and the T3 ar_load follow mem_ready
    always_comb begin
        w_pc_read  = 1'b0;
        w_pc_inc   = 1'b0;
        w_ar_load  = 1'b0;
        w_ar_read  = 1'b0;
        w_ir_read  = 1'b0;
        w_ir_load  = 1'b0;
        w_mem_read = 1'b0;
        case (r_state)
            S_T0: begin
                w_pc_read = 1'b1;
                w_ar_load = 1'b1;
            end
            S_T1: begin
                w_ar_read  = 1'b1;
                w_mem_read = 1'b1;
                w_ir_load  = bus.mem_ready;
                w_pc_inc   = bus.mem_ready;
            end
            S_T2: begin
                w_ir_read = 1'b1;
                w_ar_load = 1'b1;
            end
            S_T3: begin
                w_ar_read  = 1'b1;
                w_mem_read = 1'b1;
                w_ar_load  = bus.mem_ready;
            end
            default: begin
                w_pc_read = 1'b0;
            end
        endcase
    end

    // Wait counter is held at zero outside T1/T3, so it is clear on every entry
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wait <= 8'd0;
        end else if (w_mem_phase && !bus.mem_ready) begin
            r_wait <= r_wait + 8'd1;
        end else begin
            r_wait <= 8'd0;
        end
    end

    // Completion bookkeeping and opcode/indirect capture on leaving T2
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fetch_cnt  <= 16'd0;
            r_fetch_done <= 1'b0;
            r_opcode     <= 3'd0;
            r_indirect   <= 1'b0;
        end else begin
            r_fetch_done <= w_complete;
            if (w_complete) begin
                r_fetch_cnt <= r_fetch_cnt + 16'd1;
            end
            if (r_state == S_T2) begin
                r_opcode   <= bus.ir_in[14:12];
                r_indirect <= bus.ir_in[15];
            end
        end
    end

    assign bus.pc_read    = w_pc_read;
    assign bus.pc_inc     = w_pc_inc;
    assign bus.ar_load    = w_ar_load;
    assign bus.ar_read    = w_ar_read;
    assign bus.ir_read    = w_ir_read;
    assign bus.ir_load    = w_ir_load;
    assign bus.mem_read   = w_mem_read;
    assign bus.t_state    = r_state;
    assign bus.busy       = (r_state == S_T0) || (r_state == S_T1) ||
                            (r_state == S_T2) || (r_state == S_T3);
    assign bus.fetch_done = r_fetch_done;
    assign bus.opcode     = r_opcode;
    assign bus.indirect   = r_indirect;
    assign bus.bus_err    = (r_state == S_ERR);
    assign bus.fetch_cnt  = r_fetch_cnt;

endmodule

// File: doc/bus_fetch_ctrl.md
BUS_FETCH_CTRL -- requirements
Module: bus_fetch_ctrl

Interface
REQ-001 Parameter: TIMEOUT, 15, consecutive mem_ready-low cycles per memory access before error; legal range 1..255.
REQ-002 clk  input  1  rising-edge system clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  begin fetching from IDLE; clears the error in ERR.
REQ-005 halt  input  1  stop after the current fetch completes.
REQ-006 mem_ready  input  1  memory access complete this cycle.
REQ-007 ir_in  input  16  current IR contents; bit 15 = I, bits 14:12 = opcode.
REQ-008 pc_read  output  1  PC drives the common bus.
REQ-009 pc_inc  output  1  PC increment strobe.
REQ-010 ar_load  output  1  AR load-from-bus strobe.
REQ-011 ar_read  output  1  AR drives the address to memory.
REQ-012 ir_read  output  1  IR drives the common bus.
REQ-013 ir_load  output  1  IR load-from-bus strobe.
REQ-014 mem_read  output  1  memory drives the common bus.
REQ-015 t_state  output  3  state code: IDLE=0, T0=1, T1=2, T2=3, T3=4, ERR=7.
REQ-016 busy  output  1  high in T0..T3.
REQ-017 fetch_done  output  1  one-cycle completion pulse.
REQ-018 opcode  output  3  latched ir_in[14:12].
REQ-019 indirect  output  1  latched ir_in[15].
REQ-020 bus_err  output  1  memory timeout flag.
REQ-021 fetch_cnt  output  16  number of completed fetches.

Function
REQ-022 The FSM shall be Moore-decoded from a state register; the exceptions are ir_load, pc_inc and the T3 ar_load, which are additionally gated by mem_ready.
REQ-023 IDLE: all strobes shall be 0; start=1 at an edge shall move to T0; halt shall be ignored.
REQ-024 T0: pc_read=1 and ar_load=1 for exactly one cycle; the FSM shall then move to T1 unconditionally.
REQ-025 T1: ar_read=1 and mem_read=1; when mem_ready=1, ir_load=1 and pc_inc=1 in that cycle and the FSM moves to T2; otherwise the FSM holds in T1.
REQ-026 T2: ir_read=1 and ar_load=1 for one cycle; opcode and indirect shall latch ir_in at the edge leaving T2; next state is T3 if ir_in[15]=1, else completion.
REQ-027 T3: ar_read=1, mem_read=1, and ar_load=mem_ready; mem_ready=1 completes the fetch; otherwise the FSM holds in T3.
REQ-028 Completion edge: fetch_cnt shall increment by 1, wrapping 16'hFFFF->0; fetch_done shall be high for exactly the following cycle; next state is IDLE if halt=1, else T0 (back-to-back fetch).
REQ-029 halt shall be sampled only at the completion edge; a fetch shall never be aborted except by reset.
REQ-030 An 8-bit wait counter shall clear on entry to T1/T3 and count consecutive mem_ready=0 cycles; on the TIMEOUT-th such cycle the FSM shall move to ERR at that edge.
REQ-031 ERR: all strobes 0, busy=0, bus_err=1; start=1 shall clear bus_err, clear the wait counter and move to T0.
REQ-032 start outside IDLE/ERR shall be ignored.
REQ-033 At most one of pc_read, ar_read-with-mem_read, and ir_read shall be active in any cycle; ir_load and ar_load shall never be high in the same cycle.

Reset
REQ-034 reset=1 shall immediately, independent of clk, force IDLE and drive all strobes, busy, fetch_done and bus_err to 0.
REQ-035 reset=1 shall clear fetch_cnt, opcode, indirect and the wait counter to 0.
REQ-036 Reset mid-fetch shall abandon the fetch without counting it; operation resumes only on start after release.

Verification
REQ-037 Scenario: start pulse, mem_ready=1, ir_in=16'h7123, halt=1 -> T0,T1,T2 in 3 cycles; fetch_done one cycle; opcode=7, indirect=0, fetch_cnt=1; then IDLE.
REQ-038 Scenario: ir_in=16'h8005, mem_ready=1 -> T3 visited with ar_load=1; indirect=1, opcode=0; completes in 4 cycles.
REQ-039 Scenario: mem_ready low for 3 cycles in T1, TIMEOUT=15 -> T1 lasts 4 cycles; pc_inc and ir_load are high exactly one cycle.
REQ-040 Scenario: mem_ready held low in T1 -> ERR after 15 cycles with bus_err=1; start -> bus_err=0, t_state=1.
REQ-041 Scenario: halt=0 with 3 fetches -> back-to-back T0 with no IDLE gap; halt raised during T1 of fetch 3 -> fetch 3 completes, fetch_cnt=3, then IDLE.
REQ-042 Scenario: reset asserted mid-T1 -> outputs 0 without waiting for a clk edge; t_state=0, fetch_cnt=0.
